bw_compressor: RTL and testbench
================================

# bw_compressor

AXI4-Stream width reducer for the DDC output path. It accepts two packed 64-bit signed lanes per beat and emits two packed 48-bit signed lanes per beat, after an optional arithmetic right shift and symmetric-range saturation. It is the inverse of the 48→64-bit sign-extension stage: it brings wide accumulator/filter results back to the 96-bit sample bus. A registered skid buffer breaks both the data and the tready timing paths. Saturation events are counted for software monitoring.

## Interface
- SHIFT, 0, arithmetic right shift applied to each 64-bit lane before saturation; legal range 0..16.
- CNT_W, 32, width of the saturation event counter.

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  128  lane0 = [63:0], lane1 = [127:64], two's complement
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  registered ready
- m_axis_tdata  out  96  lane0 = [47:0], lane1 = [95:48], two's complement
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- sat_clr  in  1  single-cycle pulse; clears sat_count and sat_flag
- sat_count  out  CNT_W  number of accepted beats with at least one lane saturated; holds at all-ones
- sat_flag  out  1  sticky; set by any saturated beat

## Operation
- Per lane: t = x >>> SHIFT (arithmetic, floor, no rounding).
  - If t > 2^47−1, output 0x7FFF_FFFF_FFFF.
  - If t < −2^47, output 0x8000_0000_0000.
  - Otherwise output t[47:0].
- Lane sat bit = that lane clipped. Beat sat = lane0_sat | lane1_sat.
- Transfer rules:
  - Input accept = s_axis_tvalid & s_axis_tready.
  - Output transfer = m_axis_tvalid & m_axis_tready.
- Storage is two 96+1-bit entries: the output register (OUT) and the skid register (SKID).
- Buffer states:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- Transitions:
  - EMPTY + accept → ONE; the converted beat is loaded into OUT.
  - ONE + accept + transfer → ONE; OUT is replaced by the new beat.
  - ONE + accept + no transfer → FULL; the new beat goes into SKID.
  - ONE + transfer, no accept → EMPTY.
  - FULL + transfer → ONE; SKID moves to OUT, SKID is cleared. No accept is possible in FULL.
- s_axis_tready (registered) = next state is not FULL.
- Ordering: beats leave in acceptance order. None is dropped or duplicated.
- Data integrity: m_axis_tdata and m_axis_tvalid must not change while m_axis_tvalid=1 and m_axis_tready=0.
- Counter:
  - On each accepted beat with sat=1: sat_count increments, unless it is all-ones; sat_flag is set to 1.
  - sat_clr with no simultaneous saturated accept: sat_count ← 0, sat_flag ← 0.
  - sat_clr with a simultaneous saturated accept: sat_count ← 1, sat_flag ← 1.
- Reset mid-operation: any buffered beats are discarded immediately. No output beat is emitted for them after release.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, sat_count=0, sat_flag=0, state EMPTY.
- s_axis_tready goes to 1 on the first rising aclk edge after aresetn deasserts.
- Latency: a beat accepted at edge N has m_axis_tvalid=1 after edge N, provided the buffer was EMPTY or drained at N. The block adds one cycle of latency.
- Throughput: one beat per cycle with m_axis_tready held at 1.
- Backpressure: at most one additional beat is accepted after m_axis_tready falls. s_axis_tready is 0 in the cycle after FULL is entered.
- Recovery from FULL: s_axis_tready returns to 1 one edge after the first output transfer.
- sat_count and sat_flag update on the same edge that accepts the beat.

## Test plan
- Passthrough, SHIFT=0: lane0=0x0000_7FFF_FFFF_FFFF, lane1=0xFFFF_8000_0000_0000 → m_axis_tdata = {0x800000000000, 0x7FFFFFFFFFFF}; sat_count stays 0.
- Saturation, SHIFT=0: lane0=0x0000_8000_0000_0000, lane1=0x8000_0000_0000_0000 → lanes 0x7FFFFFFFFFFF and 0x800000000000; sat_count=1; sat_flag=1.
- Shift, SHIFT=16: lane0=−65537 (0xFFFF_FFFF_FFFE_FFFF) → 0xFFFFFFFFFFFE (−2, floor); lane1=0x7FFF_FFFF_FFFF_FFFF → 0x7FFFFFFFFFFF with no saturation.
- Backpressure: stream 1000 incrementing beats with random tvalid and tready (50%) → output sequence is identical and in order; no output change while stalled; s_axis_tready is never 1 in state FULL.
- Clear collision: sat_clr asserted on the same edge as a saturated accept, with sat_count=5 beforehand → sat_count=1 and sat_flag=1. Counter preset near all-ones plus 3 saturated beats → holds at all-ones.
- Reset mid-stream: assert aresetn=0 while the buffer is FULL → m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, s_axis_tready=1 after one edge, and no stale beat appears on the output.

Source files
------------

// File: rtl/bw_compressor_if.sv
`default_nettype none
// ============================================================================
//  Module      : bw_compressor_if
//  Description : AXI4-Stream beat channel (tdata/tvalid/tready) shared by the
//                input and output sides of bw_compressor.
//  Ports       : tdata  - DATA_W-bit beat payload
//                tvalid - beat valid (master to slave)
//                tready - beat ready (slave to master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bw_compressor_if #(
  parameter int DATA_W = 96
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/bw_compressor.sv
`default_nettype none
// ============================================================================
//  Module      : bw_compressor
//  Description : Two-lane 64-bit to 48-bit AXI4-Stream width reducer with
//                arithmetic right shift, symmetric saturation, a registered
//                two-entry skid buffer and a saturation event counter.
//  Ports       : aclk, aresetn  - clock, asynchronous active-low reset
//                s_axis (slave) - 128-bit input beats, lane0 = [63:0]
//                m_axis (master)- 96-bit output beats, lane0 = [47:0]
//                sat_clr        - pulse, clears sat_count / sat_flag
//                sat_count      - saturated accepted beats, holds at all-ones
//                sat_flag       - sticky saturation indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module bw_compressor #(
  parameter int SHIFT = 0,
  parameter int CNT_W = 32
) (
  input  wire logic             aclk,
  input  wire logic             aresetn,
  bw_compressor_if.slave        s_axis,
  bw_compressor_if.master       m_axis,
  input  wire logic             sat_clr,
  output      logic [CNT_W-1:0] sat_count,
  output      logic             sat_flag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [47:0] SAT_POS = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] SAT_NEG = 48'h8000_0000_0000;

  // Returns {clipped, lane_out}. After the shift, the value fits in 48 bits
  // only when bits [63:47] are all equal (pure sign extension).
  function automatic logic [48:0] convert(input logic [63:0] x);
    logic signed [63:0] t;
    logic               pos_ovf;
    logic               neg_ovf;
    t       = $signed(x) >>> SHIFT;
    pos_ovf = ~t[63] & (|t[62:47]);
    neg_ovf =  t[63] & ~(&t[62:47]);
    if (pos_ovf)      return {1'b1, SAT_POS};
    else if (neg_ovf) return {1'b1, SAT_NEG};
    else              return {1'b0, t[47:0]};
  endfunction

  state_t           state_q, state_d;
  logic [95:0]      out_data_q, out_data_d;
  logic [95:0]      skid_data_q, skid_data_d;
  logic             tready_q, tready_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;
  logic             sat_flag_q, sat_flag_d;

  logic [48:0]      lane0_conv;
  logic [48:0]      lane1_conv;
  logic [95:0]      conv_data;
  logic             beat_sat;
  logic             accept;
  logic             transfer;
  logic             sat_accept;

  assign lane0_conv = convert(s_axis.tdata[63:0]);
  assign lane1_conv = convert(s_axis.tdata[127:64]);
  assign conv_data  = {lane1_conv[47:0], lane0_conv[47:0]};
  assign beat_sat   = lane0_conv[48] | lane1_conv[48];

  assign accept     = s_axis.tvalid & tready_q;
  assign transfer   = (state_q != EMPTY) & m_axis.tready;
  assign sat_accept = accept & beat_sat;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = conv_data;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          out_data_d = conv_data;
        end else if (accept) begin
          skid_data_d = conv_data;
          state_d     = FULL;
        end else if (transfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // tready_q is low here, so only the drain path exists.
        if (transfer) begin
          out_data_d  = skid_data_q;
          skid_data_d = '0;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is registered from the next state, which removes the
    // m_axis_tready -> s_axis_tready combinational path.
    tready_d = (state_d != FULL);
  end

  always_comb begin
    sat_count_d = sat_count_q;
    sat_flag_d  = sat_flag_q;
    if (sat_clr) begin
      // A saturated beat on the clearing edge is counted as the first event.
      sat_count_d = sat_accept ? CNT_W'(1) : '0;
      sat_flag_d  = sat_accept;
    end else if (sat_accept) begin
      if (!(&sat_count_q)) sat_count_d = sat_count_q + CNT_W'(1);
      sat_flag_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
      tready_q    <= 1'b0;
      sat_count_q <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      tready_q    <= tready_d;
      sat_count_q <= sat_count_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = (state_q != EMPTY);
  assign m_axis.tdata  = out_data_q;
  assign sat_count     = sat_count_q;
  assign sat_flag      = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_bw_compressor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bw_compressor
//  Description : Directed self-checking bench for bw_compressor. Instance A
//                (SHIFT=0, 32-bit counter) carries most scenarios, instance B
//                uses SHIFT=16, instance C uses a 2-bit counter so the
//                all-ones hold is reachable in a few beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bw_compressor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bw_compressor_if #(.DATA_W(128)) a_s ();
  bw_compressor_if #(.DATA_W(96))  a_m ();
  bw_compressor_if #(.DATA_W(128)) b_s ();
  bw_compressor_if #(.DATA_W(96))  b_m ();
  bw_compressor_if #(.DATA_W(128)) c_s ();
  bw_compressor_if #(.DATA_W(96))  c_m ();

  logic        a_clr, b_clr, c_clr;
  logic [31:0] a_cnt, b_cnt;
  logic [1:0]  c_cnt;
  logic        a_flag, b_flag, c_flag;

  bw_compressor #(.SHIFT(0), .CNT_W(32)) u_a (
    .aclk(clk), .aresetn(rst_n), .s_axis(a_s), .m_axis(a_m),
    .sat_clr(a_clr), .sat_count(a_cnt), .sat_flag(a_flag));
  bw_compressor #(.SHIFT(16), .CNT_W(32)) u_b (
    .aclk(clk), .aresetn(rst_n), .s_axis(b_s), .m_axis(b_m),
    .sat_clr(b_clr), .sat_count(b_cnt), .sat_flag(b_flag));
  bw_compressor #(.SHIFT(0), .CNT_W(2)) u_c (
    .aclk(clk), .aresetn(rst_n), .s_axis(c_s), .m_axis(c_m),
    .sat_clr(c_clr), .sat_count(c_cnt), .sat_flag(c_flag));

  int checks = 0;
  int fails  = 0;

  // One beat into instance inst; the caller guarantees tready is high.
  task automatic send(input int inst, input logic [63:0] l0,
                      input logic [63:0] l1, input logic clr);
    case (inst)
      0: begin a_s.tdata = {l1, l0}; a_s.tvalid = 1'b1; a_clr = clr; end
      1: begin b_s.tdata = {l1, l0}; b_s.tvalid = 1'b1; b_clr = clr; end
      default: begin c_s.tdata = {l1, l0}; c_s.tvalid = 1'b1; c_clr = clr; end
    endcase
    @(posedge clk); #1;
    a_s.tvalid = 1'b0; b_s.tvalid = 1'b0; c_s.tvalid = 1'b0;
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
  endtask

  function automatic logic [127:0] bp_in(input int i);
    logic [63:0] v;
    v = 64'(i);
    return {v << 40, v};
  endfunction

  // Independent model: compare the full 64-bit value against the 48-bit limits.
  function automatic logic [95:0] bp_exp(input int i);
    logic signed [63:0] v0, v1;
    logic [47:0] o0, o1;
    v0 = 64'(i);
    v1 = v0 <<< 40;
    if (v0 > 64'sh0000_7FFF_FFFF_FFFF) o0 = 48'h7FFF_FFFF_FFFF;
    else o0 = v0[47:0];
    if (v1 > 64'sh0000_7FFF_FFFF_FFFF) o1 = 48'h7FFF_FFFF_FFFF;
    else o1 = v1[47:0];
    return {o1, o0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    a_s.tvalid = 0; b_s.tvalid = 0; c_s.tvalid = 0;
    a_s.tdata = '0; b_s.tdata = '0; c_s.tdata = '0;
    a_m.tready = 1; b_m.tready = 1; c_m.tready = 1;
    a_clr = 0; b_clr = 0; c_clr = 0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (a_m.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b exp=0", a_m.tvalid); end
    checks++; if (a_m.tdata !== 96'd0) begin fails++; $display("FAIL reset_tdata got=%h exp=0", a_m.tdata); end
    checks++; if (a_s.tready !== 1'b0) begin fails++; $display("FAIL reset_tready got=%b exp=0", a_s.tready); end
    checks++; if (a_cnt !== 32'd0 || a_flag !== 1'b0) begin fails++; $display("FAIL reset_sat got=%0d/%b exp=0/0", a_cnt, a_flag); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (a_s.tready !== 1'b0) begin fails++; $display("FAIL release_tready_early got=%b exp=0", a_s.tready); end
    @(posedge clk); #1;
    checks++; if (a_s.tready !== 1'b1) begin fails++; $display("FAIL release_tready got=%b exp=1", a_s.tready); end
  endtask

  task automatic test_passthrough();
    send(0, 64'h0000_7FFF_FFFF_FFFF, 64'hFFFF_8000_0000_0000, 1'b0);
    checks++; if (a_m.tvalid !== 1'b1) begin fails++; $display("FAIL pass_tvalid got=%b exp=1", a_m.tvalid); end
    checks++; if (a_m.tdata !== {48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF}) begin fails++; $display("FAIL pass_data got=%h exp=800000000000_7fffffffffff", a_m.tdata); end
    checks++; if (a_cnt !== 32'd0 || a_flag !== 1'b0) begin fails++; $display("FAIL pass_sat got=%0d/%b exp=0/0", a_cnt, a_flag); end
  endtask

  task automatic test_saturation();
    send(0, 64'h0000_8000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    checks++; if (a_m.tdata !== {48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF}) begin fails++; $display("FAIL sat_data got=%h exp=800000000000_7fffffffffff", a_m.tdata); end
    checks++; if (a_cnt !== 32'd1 || a_flag !== 1'b1) begin fails++; $display("FAIL sat_count got=%0d/%b exp=1/1", a_cnt, a_flag); end
    send(0, 64'hFFFF_7FFF_FFFF_FFFF, 64'h0000_0000_0000_0005, 1'b0);
    checks++; if (a_m.tdata !== {48'h0000_0000_0005, 48'h8000_0000_0000}) begin fails++; $display("FAIL sat_neg_data got=%h exp=000000000005_800000000000", a_m.tdata); end
    checks++; if (a_cnt !== 32'd2) begin fails++; $display("FAIL sat_count2 got=%0d exp=2", a_cnt); end
  endtask

  task automatic test_shift();
    send(1, 64'hFFFF_FFFF_FFFE_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    checks++; if (b_m.tdata !== {48'h7FFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFE}) begin fails++; $display("FAIL shift_data got=%h exp=7fffffffffff_fffffffffffe", b_m.tdata); end
    checks++; if (b_cnt !== 32'd0 || b_flag !== 1'b0) begin fails++; $display("FAIL shift_sat got=%0d/%b exp=0/0", b_cnt, b_flag); end
    send(1, 64'h8000_0000_0000_0000, 64'h0000_0000_0003_0000, 1'b0);
    checks++; if (b_m.tdata !== {48'h0000_0000_0003, 48'h8000_0000_0000}) begin fails++; $display("FAIL shift_min got=%h exp=000000000003_800000000000", b_m.tdata); end
  endtask

  task automatic test_clear_collision();
    for (int k = 0; k < 3; k++) send(0, 64'h7000_0000_0000_0000, 64'd0, 1'b0);
    checks++; if (a_cnt !== 32'd5) begin fails++; $display("FAIL clr_pre got=%0d exp=5", a_cnt); end
    send(0, 64'h7000_0000_0000_0000, 64'd0, 1'b1);
    checks++; if (a_cnt !== 32'd1 || a_flag !== 1'b1) begin fails++; $display("FAIL clr_collide got=%0d/%b exp=1/1", a_cnt, a_flag); end
    a_clr = 1'b1; @(posedge clk); #1; a_clr = 1'b0;
    checks++; if (a_cnt !== 32'd0 || a_flag !== 1'b0) begin fails++; $display("FAIL clr_plain got=%0d/%b exp=0/0", a_cnt, a_flag); end
    send(0, 64'd1, 64'd2, 1'b0);
    checks++; if (a_cnt !== 32'd0 || a_flag !== 1'b0) begin fails++; $display("FAIL clr_nosat got=%0d/%b exp=0/0", a_cnt, a_flag); end
  endtask

  task automatic test_sat_hold();
    for (int k = 0; k < 3; k++) send(2, 64'd0, 64'h8000_0000_0000_0000, 1'b0);
    checks++; if (c_cnt !== 2'd3 || c_flag !== 1'b1) begin fails++; $display("FAIL hold_reach got=%0d/%b exp=3/1", c_cnt, c_flag); end
    for (int k = 0; k < 3; k++) send(2, 64'h0001_0000_0000_0000, 64'd0, 1'b0);
    checks++; if (c_cnt !== 2'd3 || c_flag !== 1'b1) begin fails++; $display("FAIL hold_stay got=%0d/%b exp=3/1", c_cnt, c_flag); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] neg;
    a_m.tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      neg = -64'(k);
      a_s.tdata = {neg, 64'(k * 3)}; a_s.tvalid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_m.tvalid !== 1'b1 || a_s.tready !== 1'b1 || a_m.tdata !== {neg[47:0], 48'(k * 3)}) begin
        fails++; $display("FAIL b2b_beat%0d got=%b/%b/%h exp=1/1/%h", k, a_m.tvalid, a_s.tready, a_m.tdata, {neg[47:0], 48'(k * 3)});
      end
    end
    a_s.tvalid = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_m.tvalid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", a_m.tvalid); end
  endtask

  task automatic test_full_recovery();
    a_m.tready = 1'b0;
    send(0, 64'h11, 64'h22, 1'b0);
    checks++; if (a_s.tready !== 1'b1) begin fails++; $display("FAIL full_one_ready got=%b exp=1", a_s.tready); end
    send(0, 64'h33, 64'h44, 1'b0);
    checks++; if (a_s.tready !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", a_s.tready); end
    a_s.tdata = {64'h66, 64'h55}; a_s.tvalid = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (a_m.tdata !== {48'h22, 48'h11} || a_m.tvalid !== 1'b1) begin fails++; $display("FAIL full_stall got=%h exp=%h", a_m.tdata, {48'h22, 48'h11}); end
    a_s.tvalid = 1'b0;
    a_m.tready = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_s.tready !== 1'b1 || a_m.tdata !== {48'h44, 48'h33}) begin fails++; $display("FAIL full_recover got=%b/%h exp=1/%h", a_s.tready, a_m.tdata, {48'h44, 48'h33}); end
    @(posedge clk); #1;
    checks++; if (a_m.tvalid !== 1'b0) begin fails++; $display("FAIL full_drained got=%b exp=0", a_m.tvalid); end
  endtask

  task automatic test_backpressure();
    int tx, rx, occ, cyc;
    logic acc, xfer, prev_stall;
    logic [95:0] prev_data;
    tx = 0; rx = 0; occ = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    a_s.tdata  = bp_in(0);
    a_s.tvalid = 1'($urandom_range(0, 1));
    a_m.tready = 1'($urandom_range(0, 1));
    while (rx < 1000 && cyc < 20000) begin
      @(negedge clk);
      acc  = a_s.tvalid & a_s.tready;
      xfer = a_m.tvalid & a_m.tready;
      checks++; if (a_s.tready !== (occ != 2)) begin fails++; $display("FAIL bp_ready cyc=%0d got=%b occ=%0d", cyc, a_s.tready, occ); end
      checks++; if (a_m.tvalid !== (occ != 0)) begin fails++; $display("FAIL bp_valid cyc=%0d got=%b occ=%0d", cyc, a_m.tvalid, occ); end
      if (prev_stall) begin
        checks++; if (a_m.tdata !== prev_data) begin fails++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, a_m.tdata, prev_data); end
      end
      if (xfer) begin
        checks++; if (a_m.tdata !== bp_exp(rx)) begin fails++; $display("FAIL bp_data beat=%0d got=%h exp=%h", rx, a_m.tdata, bp_exp(rx)); end
        rx++;
      end
      prev_stall = a_m.tvalid & ~a_m.tready;
      prev_data  = a_m.tdata;
      if (acc) tx++;
      occ = occ + int'(acc) - int'(xfer);
      @(posedge clk); #1;
      if (!(a_s.tvalid && !acc)) begin
        a_s.tvalid = (tx < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        a_s.tdata  = bp_in(tx);
      end
      a_m.tready = 1'($urandom_range(0, 1));
      cyc++;
    end
    checks++; if (rx != 1000) begin fails++; $display("FAIL bp_count got=%0d exp=1000", rx); end
    a_s.tvalid = 1'b0; a_m.tready = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    a_m.tready = 1'b0;
    send(0, 64'h77, 64'h88, 1'b0);
    send(0, 64'h99, 64'hAA, 1'b0);
    checks++; if (a_s.tready !== 1'b0 || a_m.tvalid !== 1'b1) begin fails++; $display("FAIL rmid_full got=%b/%b exp=0/1", a_s.tready, a_m.tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_m.tvalid !== 1'b0 || a_s.tready !== 1'b0) begin fails++; $display("FAIL rmid_async got=%b/%b exp=0/0", a_m.tvalid, a_s.tready); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; a_m.tready = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_s.tready !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%b exp=1", a_s.tready); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (a_m.tvalid !== 1'b0) begin fails++; $display("FAIL rmid_stale cyc=%0d got=%b exp=0", k, a_m.tvalid); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_shift();
    test_clear_collision();
    test_sat_hold();
    test_back_to_back();
    test_full_recovery();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
